// File: rtl/free_list_if.sv
// Rename/commit-side bundle for the physical-register free list.
interface free_list_if #(
  parameter int PHY_REG_SEL = 6,
  parameter int CNT_W       = 6
);
  logic                   alloc_req_1;
  logic                   alloc_req_2;
  logic [PHY_REG_SEL-1:0] phy_dst_1_from_free_list;
  logic [PHY_REG_SEL-1:0] phy_dst_2_from_free_list;
  logic                   alloc_stall;
  logic                   commit_valid_1;
  logic                   commit_valid_2;
  logic [PHY_REG_SEL-1:0] commit_old_phy_1;
  logic [PHY_REG_SEL-1:0] commit_old_phy_2;
  logic                   flush;
  logic [CNT_W-1:0]       free_count;
  logic                   fl_error;

  modport master (
    output alloc_req_1, alloc_req_2,
    output commit_valid_1, commit_valid_2,
    output commit_old_phy_1, commit_old_phy_2,
    output flush,
    input  phy_dst_1_from_free_list,
    input  phy_dst_2_from_free_list,
    input  alloc_stall, free_count, fl_error
  );

  modport slave (
    input  alloc_req_1, alloc_req_2,
    input  commit_valid_1, commit_valid_2,
    input  commit_old_phy_1, commit_old_phy_2,
    input  flush,
    output phy_dst_1_from_free_list,
    output phy_dst_2_from_free_list,
    output alloc_stall, free_count, fl_error
  );
endinterface

// File: rtl/free_list.sv
// Two-wide physical-register free list with flush rollback.
// FREE_LIST_CHECK_EN enables the sticky fl_error overflow/zero-tag check.
module free_list #(
  parameter int NUM_PHY_REGS  = 64,
  parameter int NUM_ARCH_REGS = 32
) (
  input  logic      clk,
  input  logic      reset,
  free_list_if.slave fl
);
  localparam int PHY_REG_SEL = $clog2(NUM_PHY_REGS);
  localparam int FL_DEPTH    = NUM_PHY_REGS - NUM_ARCH_REGS;
  localparam int IW          = $clog2(FL_DEPTH);
  localparam int PW          = IW + 1;

  typedef logic [PW-1:0]          ptr_t;
  typedef logic [IW-1:0]          idx_t;
  typedef logic [PHY_REG_SEL-1:0] tag_t;

  tag_t r_mem [FL_DEPTH];
  ptr_t r_head;
  ptr_t r_retire_head;
  ptr_t r_tail;
  ptr_t r_free_count;

  ptr_t w_req_n;
  ptr_t w_commit_n;
  idx_t w_rd_idx;
  idx_t w_rd_idx_p1;
  idx_t w_wr_idx_a;
  idx_t w_wr_idx_b;
  logic w_fire;
  ptr_t w_head_nxt;
  ptr_t w_tail_nxt;
  ptr_t w_ret_nxt;

  assign w_req_n = ptr_t'(fl.alloc_req_1)
                 + ptr_t'(fl.alloc_req_2);
  assign w_commit_n = ptr_t'(fl.commit_valid_1)
                    + ptr_t'(fl.commit_valid_2);

  assign w_rd_idx    = r_head[IW-1:0];
  assign w_rd_idx_p1 = w_rd_idx + idx_t'(1);

  assign fl.phy_dst_1_from_free_list = r_mem[w_rd_idx];
  assign fl.phy_dst_2_from_free_list =
    fl.alloc_req_1 ? r_mem[w_rd_idx_p1]
                   : r_mem[w_rd_idx];

  // Compared against the registered count, so same-cycle frees never help.
  assign fl.alloc_stall = w_req_n > r_free_count;
  assign w_fire = (w_req_n != '0) && !fl.alloc_stall
                && !fl.flush;

  assign w_wr_idx_a = r_tail[IW-1:0];
  assign w_wr_idx_b = fl.commit_valid_1
                    ? w_wr_idx_a + idx_t'(1)
                    : w_wr_idx_a;

  assign w_tail_nxt = r_tail + w_commit_n;
  assign w_ret_nxt  = r_retire_head + w_commit_n;

  always_comb begin
    w_head_nxt = r_head;
    unique case (1'b1)
      fl.flush: w_head_nxt = w_ret_nxt;
      w_fire:   w_head_nxt = r_head + w_req_n;
      default:  w_head_nxt = r_head;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FL_DEPTH; i++)
        r_mem[i] <= tag_t'(NUM_ARCH_REGS + i);
      r_head        <= '0;
      r_retire_head <= '0;
      r_tail        <= ptr_t'(FL_DEPTH);
      r_free_count  <= ptr_t'(FL_DEPTH);
    end else begin
      if (fl.commit_valid_1)
        r_mem[w_wr_idx_a] <= fl.commit_old_phy_1;
      if (fl.commit_valid_2)
        r_mem[w_wr_idx_b] <= fl.commit_old_phy_2;
      r_head        <= w_head_nxt;
      r_retire_head <= w_ret_nxt;
      r_tail        <= w_tail_nxt;
      r_free_count  <= w_tail_nxt - w_head_nxt;
    end
  end

  assign fl.free_count = r_free_count;

`ifdef FREE_LIST_CHECK_EN
  localparam logic [PW:0] LP_FULL = FL_DEPTH;

  logic        r_fl_error;
  logic [PW:0] w_fill;
  logic        w_over;
  logic        w_zero;

  assign w_fill = {1'b0, r_free_count}
                + {1'b0, w_commit_n};
  assign w_over = w_fill > LP_FULL;
  assign w_zero =
    (fl.commit_valid_1 && fl.commit_old_phy_1 == '0) ||
    (fl.commit_valid_2 && fl.commit_old_phy_2 == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_fl_error <= 1'b0;
    else
      r_fl_error <= r_fl_error | w_over | w_zero;
  end

  assign fl.fl_error = r_fl_error;
`else
  assign fl.fl_error = 1'b0;
`endif
endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed scenarios plus
// randomized traffic against a queue-based free-tag model.
module tb_free_list;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

`ifdef FREE_LIST_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  free_list_if #(.PHY_REG_SEL(6), .CNT_W(6)) fl_if ();

  free_list #(.NUM_PHY_REGS(64), .NUM_ARCH_REGS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .fl    (fl_if)
  );

  task automatic drive(input logic a1, input logic a2,
                       input logic c1, input logic c2,
                       input logic [5:0] o1, input logic [5:0] o2,
                       input logic f);
    @(negedge clk);
    fl_if.alloc_req_1      = a1;
    fl_if.alloc_req_2      = a2;
    fl_if.commit_valid_1   = c1;
    fl_if.commit_valid_2   = c2;
    fl_if.commit_old_phy_1 = o1;
    fl_if.commit_old_phy_2 = o2;
    fl_if.flush            = f;
    #2;
  endtask

  task automatic idle;
    drive(0, 0, 0, 0, 6'd0, 6'd0, 0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    fl_if.alloc_req_1 = 0; fl_if.alloc_req_2 = 0;
    fl_if.commit_valid_1 = 0; fl_if.commit_valid_2 = 0;
    fl_if.commit_old_phy_1 = 0; fl_if.commit_old_phy_2 = 0;
    fl_if.flush = 0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    idle();
    reset = 1'b0;
    #1;
    n_chk++;
    if (fl_if.free_count !== 6'd32) begin
      n_fail++;
      $display("FAIL reset_fc: got %0d want 32", fl_if.free_count);
    end
    n_chk++;
    if (fl_if.alloc_stall !== 1'b0 || fl_if.fl_error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: stall=%b err=%b want 0 0",
               fl_if.alloc_stall, fl_if.fl_error);
    end
    n_chk++;
    if (fl_if.phy_dst_1_from_free_list !== 6'd32) begin
      n_fail++;
      $display("FAIL reset_tag: got %0d want 32",
               fl_if.phy_dst_1_from_free_list);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(1, 1, 0, 0, 6'd0, 6'd0, 0);
    tick();
    tick();
    idle();
    // Assert reset away from any clock edge: it must act at once.
    reset = 1'b0;
    #1;
    n_chk++;
    if (fl_if.free_count !== 6'd32 ||
        fl_if.phy_dst_1_from_free_list !== 6'd32) begin
      n_fail++;
      $display("FAIL async_reset: fc=%0d tag=%0d want 32 32",
               fl_if.free_count, fl_if.phy_dst_1_from_free_list);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_dual_alloc;
    do_reset();
    drive(1, 1, 0, 0, 6'd0, 6'd0, 0);
    n_chk++;
    if (fl_if.phy_dst_1_from_free_list !== 6'd32 ||
        fl_if.phy_dst_2_from_free_list !== 6'd33) begin
      n_fail++;
      $display("FAIL dual_first: got %0d/%0d want 32/33",
               fl_if.phy_dst_1_from_free_list,
               fl_if.phy_dst_2_from_free_list);
    end
    tick();
    n_chk++;
    if (fl_if.free_count !== 6'd30) begin
      n_fail++;
      $display("FAIL dual_fc: got %0d want 30", fl_if.free_count);
    end
    n_chk++;
    if (fl_if.phy_dst_1_from_free_list !== 6'd34 ||
        fl_if.phy_dst_2_from_free_list !== 6'd35) begin
      n_fail++;
      $display("FAIL dual_second: got %0d/%0d want 34/35",
               fl_if.phy_dst_1_from_free_list,
               fl_if.phy_dst_2_from_free_list);
    end
    idle();
  endtask

  task automatic test_slot2_only;
    do_reset();
    drive(0, 1, 0, 0, 6'd0, 6'd0, 0);
    n_chk++;
    if (fl_if.phy_dst_2_from_free_list !== 6'd32) begin
      n_fail++;
      $display("FAIL slot2_tag: got %0d want 32",
               fl_if.phy_dst_2_from_free_list);
    end
    tick();
    idle();
    n_chk++;
    if (fl_if.free_count !== 6'd31 ||
        fl_if.phy_dst_1_from_free_list !== 6'd33) begin
      n_fail++;
      $display("FAIL slot2_adv: fc=%0d tag=%0d want 31 33",
               fl_if.free_count, fl_if.phy_dst_1_from_free_list);
    end
  endtask

  task automatic test_stall_commit;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(1, 1, 0, 0, 6'd0, 6'd0, 0);
      tick();
    end
    drive(1, 0, 0, 0, 6'd0, 6'd0, 0);
    tick();
    drive(1, 1, 1, 0, 6'd5, 6'd0, 0);
    n_chk++;
    if (fl_if.free_count !== 6'd1 || fl_if.alloc_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_set: fc=%0d stall=%b want 1 1",
               fl_if.free_count, fl_if.alloc_stall);
    end
    tick();
    drive(1, 1, 0, 0, 6'd0, 6'd0, 0);
    n_chk++;
    if (fl_if.alloc_stall !== 1'b0 ||
        fl_if.phy_dst_1_from_free_list !== 6'd63 ||
        fl_if.phy_dst_2_from_free_list !== 6'd5) begin
      n_fail++;
      $display("FAIL stall_release: stall=%b tags=%0d/%0d want 0 63/5",
               fl_if.alloc_stall, fl_if.phy_dst_1_from_free_list,
               fl_if.phy_dst_2_from_free_list);
    end
    tick();
    idle();
    n_chk++;
    if (fl_if.free_count !== 6'd0) begin
      n_fail++;
      $display("FAIL stall_empty: fc=%0d want 0", fl_if.free_count);
    end
  endtask

  task automatic test_wrap;
    int exp_q[$];
    int bad = 0;
    do_reset();
    for (int t = 32; t < 64; t++) exp_q.push_back(t);
    for (int k = 0; k < 40; k++) begin
      logic [5:0] tag;
      tag = 6'((k % 31) + 1);
      drive(1, 0, 0, 0, 6'd0, 6'd0, 0);
      n_chk++;
      if (fl_if.phy_dst_1_from_free_list !== 6'(exp_q[0])) begin
        n_fail++;
        $display("FAIL wrap_tag[%0d]: got %0d want %0d", k,
                 fl_if.phy_dst_1_from_free_list, exp_q[0]);
      end
      void'(exp_q.pop_front());
      tick();
      if (fl_if.free_count !== 6'd31) bad++;
      drive(0, 0, 1, 0, tag, 6'd0, 0);
      exp_q.push_back(int'(tag));
      tick();
      if (fl_if.free_count !== 6'd32) bad++;
    end
    idle();
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL wrap_fc: %0d out-of-range counts, want 0", bad);
    end
  endtask

  task automatic test_flush;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 6'd0, 6'd0, 0);
      tick();
    end
    drive(0, 0, 1, 1, 6'd1, 6'd2, 0);
    tick();
    drive(1, 1, 1, 0, 6'd3, 6'd0, 1);
    tick();
    drive(1, 1, 0, 0, 6'd0, 6'd0, 0);
    n_chk++;
    if (fl_if.free_count !== 6'd32) begin
      n_fail++;
      $display("FAIL flush_fc: got %0d want 32", fl_if.free_count);
    end
    n_chk++;
    if (fl_if.phy_dst_1_from_free_list !== 6'd35 ||
        fl_if.phy_dst_2_from_free_list !== 6'd36) begin
      n_fail++;
      $display("FAIL flush_tags: got %0d/%0d want 35/36",
               fl_if.phy_dst_1_from_free_list,
               fl_if.phy_dst_2_from_free_list);
    end
    tick();
    idle();
  endtask

  task automatic test_error;
    do_reset();
    drive(0, 0, 1, 0, 6'd7, 6'd0, 0);
    tick();
    idle();
    tick();
    tick();
    n_chk++;
    if (fl_if.fl_error !== EXP_ERR) begin
      n_fail++;
      $display("FAIL err_overflow: got %b want %b", fl_if.fl_error, EXP_ERR);
    end
    do_reset();
    drive(1, 1, 0, 0, 6'd0, 6'd0, 0);
    tick();
    drive(0, 0, 1, 0, 6'd9, 6'd0, 0);
    tick();
    idle();
    n_chk++;
    if (fl_if.fl_error !== 1'b0) begin
      n_fail++;
      $display("FAIL err_legal: got %b want 0", fl_if.fl_error);
    end
    drive(0, 0, 0, 1, 6'd0, 6'd0, 0);
    tick();
    idle();
    n_chk++;
    if (fl_if.fl_error !== EXP_ERR) begin
      n_fail++;
      $display("FAIL err_zero_tag: got %b want %b", fl_if.fl_error, EXP_ERR);
    end
  endtask

  task automatic test_random;
    int free_q[$];
    int infl[$];
    do_reset();
    for (int t = 32; t < 64; t++) free_q.push_back(t);
    for (int k = 0; k < 400; k++) begin
      logic a1, a2, c1, c2, f, stall, fire;
      logic [5:0] o1, o2;
      int req, cn;
      a1 = 1'($urandom_range(0, 1));
      a2 = 1'($urandom_range(0, 1));
      c1 = (infl.size() >= 1) && ($urandom_range(0, 2) == 0);
      c2 = (infl.size() >= int'(c1) + 1) && ($urandom_range(0, 2) == 0);
      o1 = 6'($urandom_range(1, 63));
      o2 = 6'($urandom_range(1, 63));
      f  = ($urandom_range(0, 15) == 0);
      drive(a1, a2, c1, c2, o1, o2, f);
      req = int'(a1) + int'(a2);
      stall = req > free_q.size();
      n_chk++;
      if (fl_if.alloc_stall !== stall) begin
        n_fail++;
        $display("FAIL rnd_stall[%0d]: got %b want %b",
                 k, fl_if.alloc_stall, stall);
      end
      if (!stall && a1) begin
        n_chk++;
        if (fl_if.phy_dst_1_from_free_list !== 6'(free_q[0])) begin
          n_fail++;
          $display("FAIL rnd_tag1[%0d]: got %0d want %0d", k,
                   fl_if.phy_dst_1_from_free_list, free_q[0]);
        end
      end
      if (!stall && a2) begin
        n_chk++;
        if (fl_if.phy_dst_2_from_free_list !==
            6'(a1 ? free_q[1] : free_q[0])) begin
          n_fail++;
          $display("FAIL rnd_tag2[%0d]: got %0d want %0d", k,
                   fl_if.phy_dst_2_from_free_list,
                   a1 ? free_q[1] : free_q[0]);
        end
      end
      fire = (req != 0) && !stall && !f;
      if (fire)
        for (int j = 0; j < req; j++) infl.push_back(free_q.pop_front());
      cn = int'(c1) + int'(c2);
      for (int j = 0; j < cn; j++) void'(infl.pop_front());
      if (f) begin
        free_q = {infl, free_q};
        infl.delete();
      end
      if (c1) free_q.push_back(int'(o1));
      if (c2) free_q.push_back(int'(o2));
      tick();
      n_chk++;
      if (fl_if.free_count !== 6'(free_q.size()) ||
          fl_if.fl_error !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_fc[%0d]: fc=%0d err=%b want %0d 0", k,
                 fl_if.free_count, fl_if.fl_error, free_q.size());
      end
    end
    idle();
  endtask

  initial begin
    fl_if.alloc_req_1 = 0; fl_if.alloc_req_2 = 0;
    fl_if.commit_valid_1 = 0; fl_if.commit_valid_2 = 0;
    fl_if.commit_old_phy_1 = 0; fl_if.commit_old_phy_2 = 0;
    fl_if.flush = 0;
    test_reset();
    test_dual_alloc();
    test_slot2_only();
    test_stall_commit();
    test_wrap();
    test_flush();
    test_error();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/free_list.md
# free_list

Physical-register free list for the two-wide rename stage. Each cycle it presents up to two free physical register tags to the renaming logic, which consumes them as `phy_dst_1_from_free_list` / `phy_dst_2_from_free_list`. Commit returns superseded tags. On a pipeline flush it rolls speculative allocations back to the committed state.

## Interface
- `NUM_PHY_REGS`, 64, physical registers; power of two; `PHY_REG_SEL` = log2(`NUM_PHY_REGS`)
- `NUM_ARCH_REGS`, 32, architectural registers; `FL_DEPTH` = `NUM_PHY_REGS` − `NUM_ARCH_REGS` (power of two)
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-low (0 = reset asserted)
- `alloc_req_1` in 1: rename slot 1 needs a destination
- `alloc_req_2` in 1: rename slot 2 needs a destination
- `phy_dst_1_from_free_list` out `PHY_REG_SEL`: tag for slot 1
- `phy_dst_2_from_free_list` out `PHY_REG_SEL`: tag for slot 2
- `alloc_stall` out 1: the request cannot be satisfied this cycle
- `commit_valid_1` in 1: oldest committing instruction has a destination
- `commit_valid_2` in 1: second committing instruction has a destination
- `commit_old_phy_1` in `PHY_REG_SEL`: tag freed by commit 1
- `commit_old_phy_2` in `PHY_REG_SEL`: tag freed by commit 2
- `flush` in 1: squash all uncommitted allocations
- `free_count` out log2(`FL_DEPTH`)+1: speculative free entries
- `fl_error` out 1: sticky error flag; see Configuration

## Operation
- Circular buffer `mem[FL_DEPTH]` with three pointers, each log2(`FL_DEPTH`)+1 bits (MSB is the wrap bit):
  - `head`: speculative read pointer
  - `retire_head`: committed read pointer
  - `tail`: write pointer
- `free_count` = `tail` − `head` (modular). It is registered.
- Read-out is combinational from the current `head`:
  - `phy_dst_1_from_free_list` = `mem[head]`
  - `phy_dst_2_from_free_list` = `alloc_req_1 ? mem[head+1] : mem[head]`
  - Index arithmetic wraps modulo `FL_DEPTH`.
- `req_n` = `alloc_req_1` + `alloc_req_2`.
- `alloc_stall` = (`req_n` > `free_count`). Allocation is all-or-nothing.
- `alloc_fire` = `req_n` != 0 && !`alloc_stall` && !`flush`. On fire, `head` += `req_n`.
- Commit:
  - `commit_n` = `commit_valid_1` + `commit_valid_2`.
  - Tags are written at `tail` in slot order: commit 1 first, then commit 2 (at `tail`+1 if both, at `tail` if only commit 2).
  - `tail` += `commit_n`; `retire_head` += `commit_n`.
- Flush:
  - `head` <= `retire_head` + `commit_n`. This includes commits in the same cycle.
  - Allocation in a flush cycle is discarded.
  - Commits in a flush cycle are fully performed.

## Timing
- Reset (async assert, sync-clean deassert), all values hold while `reset`=0:
  - `mem[i]` = `NUM_ARCH_REGS` + i
  - `head` = 0, `retire_head` = 0
  - `tail` = `FL_DEPTH` with wrap bit set (full)
  - `free_count` = `FL_DEPTH`, `alloc_stall` = 0, `fl_error` = 0
- Allocation latency 0: tags are valid in the request cycle, and `head` advances at the next edge.
- Freed tags become allocatable the cycle after commit. A same-cycle free never satisfies a stalled request.
- Wrap-around: pointers wrap modulo 2·`FL_DEPTH`. Full is `tail`−`head` = `FL_DEPTH`; empty is 0.
- Alloc + commit in the same cycle: `free_count` next = `free_count` − `req_n`·fire + `commit_n`.
- A reset asserted mid-operation discards all in-flight state immediately.

## Configuration
- `FREE_LIST_CHECK_EN` defined:
  - `fl_error` sets (sticky until reset) if a commit would push beyond full, i.e. `free_count` + `commit_n` > `FL_DEPTH` in the absence of allocation.
  - It also sets if `commit_old_phy_x` is 0 with `commit_valid_x`=1.
  - The offending write is still performed.
- Not defined: `fl_error` is tied to 0 and the check logic is absent.

## Test plan
- Reset, then `alloc_req_1`=`alloc_req_2`=1 -> tags 32/33 the same cycle; next cycle `free_count`=30 and tags 34/35.
- `alloc_req_1`=0, `alloc_req_2`=1 at reset -> `phy_dst_2_from_free_list`=32; `head` advances by 1.
- Drain to `free_count`=1, then request 2 -> `alloc_stall`=1 and `head` unchanged. Commit freeing tag 5 in the same cycle -> still stalled; next cycle dual alloc succeeds with tags 63 and 5.
- 40 cycles of alternating single alloc/commit -> pointers wrap; returned tags emerge in FIFO order; `free_count` stays within 31..32.
- Allocate 6 tags, commit 2 (old tags 1, 2), then `flush` with one commit (old tag 3) -> `head`=`retire_head`=3; `free_count`=32; next allocations return 35, 36.
- With `FREE_LIST_CHECK_EN`: commit at `free_count`=32 -> `fl_error`=1 and it stays 1. Without the macro, the same stimulus -> `fl_error`=0.
